// File: rtl/ram_frame_reader_if.sv
// Pixel-stream and RAM read-port signals of the frame reader.
// The master modport is the reader; the slave modport is the RAM plus the pixel sink.
interface ram_frame_reader_if #(
  parameter int V = 8,
  parameter int A = 20
);
  logic         ram_we_o;
  logic [A-1:0] ram_addr_o;
  logic [V-1:0] ram_data_i;
  logic [V-1:0] pix_data_o;
  logic         pix_valid_o;
  logic         pix_ready_i;
  logic         pix_last_o;

  modport master (
    output ram_we_o,
    output ram_addr_o,
    input  ram_data_i,
    output pix_data_o,
    output pix_valid_o,
    input  pix_ready_i,
    output pix_last_o
  );

  modport slave (
    input  ram_we_o,
    input  ram_addr_o,
    output ram_data_i,
    input  pix_data_o,
    input  pix_valid_o,
    output pix_ready_i,
    input  pix_last_o
  );
endinterface

// File: rtl/ram_frame_reader.sv
// Streams one frame of S pixels from a registered-read RAM into a valid/ready pixel port,
// keeping at most two pixels buffered or in flight so back-pressure never drops data.
module ram_frame_reader #(
  parameter int V = 8,
  parameter int S = 76800,
  parameter int A = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  ram_frame_reader_if.master io,
  output logic             busy_o,
  output logic             done_o
);

  if (S < 1 || S > (2 ** A)) begin : g_bad_params
    $error("ram_frame_reader: address width A cannot hold S-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [A-1:0] LAST_ADDR = A'(S - 1);

  state_t       r_state;
  state_t       w_stateNext;
  logic [A-1:0] r_addr;
  logic         r_inflight;
  logic         r_inflightLast;
  logic [V-1:0] r_bufData [2];
  logic         r_bufLast [2];
  logic         r_rdPtr;
  logic         r_wrPtr;
  logic [1:0]   r_count;
  logic         r_done;

  logic         w_valid;
  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  logic         w_issueLast;
  logic         w_lastPop;
  logic         w_start;

  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid & io.pix_ready_i;
  assign w_push      = r_inflight;
  assign w_issueLast = (r_addr == LAST_ADDR);
  assign w_start     = (r_state == IDLE) & start_i;

  // A read may only be issued if the buffer will still have room when its data lands.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_lastPop   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        w_issue = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
        if (w_issue && w_issueLast) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        w_lastPop = w_pop & r_bufLast[r_rdPtr];
        if (w_lastPop) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The counter parks on S-1 after the final issue rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr         <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
    end else begin
      r_inflight     <= w_issue;
      r_inflightLast <= w_issue & w_issueLast;
      if (w_start) begin
        r_addr <= '0;
      end else if (w_issue && !w_issueLast) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bufData[0] <= '0;
      r_bufData[1] <= '0;
      r_bufLast[0] <= 1'b0;
      r_bufLast[1] <= 1'b0;
      r_rdPtr      <= 1'b0;
      r_wrPtr      <= 1'b0;
      r_count      <= 2'd0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_lastPop;
      if (w_push) begin
        r_bufData[r_wrPtr] <= io.ram_data_i;
        r_bufLast[r_wrPtr] <= r_inflightLast;
        r_wrPtr            <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io.ram_we_o    = 1'b0;
  assign io.ram_addr_o  = r_addr;
  assign io.pix_valid_o = w_valid;
  assign io.pix_data_o  = w_valid ? r_bufData[r_rdPtr] : '0;
  assign io.pix_last_o  = w_valid & r_bufLast[r_rdPtr];
  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;

endmodule
